// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive controller: FSM states, sync/stuffing
// constants and bit-timing constants.
package usb_rx_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'h80;
  localparam int         STUFF_LIMIT  = 6;
  localparam int         BIT_PERIOD   = 8;
  localparam int         SAMPLE_PHASE = 3;
  localparam int         PHASE_W      = $clog2(BIT_PERIOD);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SYNC_RCV = 3'd1,
    CHK_SYNC = 3'd2,
    RCV_BYTE = 3'd3,
    STORE    = 3'd4,
    EOP_WAIT = 3'd5,
    ERR_WAIT = 3'd6,
    EIDLE    = 3'd7
  } rx_state_t;

  // Every state between the first edge and the return to an idle state counts as receiving.
  function automatic logic isRcving(input rx_state_t s);
    return !((s == IDLE) || (s == EIDLE));
  endfunction

endpackage

// File: rtl/rx_timer.sv
// Bit-cell timer: tracks the phase within a bit period, resynchronising on
// every D+ edge, and raises a raw sample strobe mid-cell.
module rx_timer
  import usb_rx_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic i_d_edge,
  input  logic i_rcving,
  output logic o_sample
);

  logic [PHASE_W-1:0] r_phase;

  // The edge cycle itself is phase 0, so the register already reads phase 1
  // in the following cycle; this puts the sample three cycles after the edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_phase <= '0;
    end else if (i_d_edge) begin
      r_phase <= PHASE_W'(1);
    end else if (i_rcving) begin
      r_phase <= r_phase + 1'b1;
    end else begin
      r_phase <= '0;
    end
  end

  assign o_sample = (r_phase == PHASE_W'(SAMPLE_PHASE)) && !i_d_edge;

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB receive controller: bit unstuffing, accepted-bit counting and the
// packet-level FSM that validates sync, stores bytes and flags errors.
module usb_rx_ctrl #(
  parameter logic [7:0] SYNC_BYTE   = usb_rx_pkg::SYNC_BYTE,
  parameter int         STUFF_LIMIT = usb_rx_pkg::STUFF_LIMIT
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       d_orig,
  input  logic [7:0] rcv_data,
  output logic       shift_enable,
  output logic       byte_received,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error
);

  import usb_rx_pkg::*;

  localparam int ONES_W = $clog2(STUFF_LIMIT + 1);

  rx_state_t r_state;
  rx_state_t w_nextState;

  logic              w_sample;
  logic              w_sampling;
  logic              w_stuffed;
  logic              w_stuffErr;
  logic              w_startPkt;
  logic              w_eopFall;
  logic              w_rcving;
  logic              w_wEnable;
  logic [2:0]        r_bitCnt;
  logic [ONES_W-1:0] r_onesCnt;
  logic              r_byteRcvd;
  logic              r_eopD;
  logic              r_err;

  rx_timer u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_d_edge (d_edge),
    .i_rcving (w_rcving),
    .o_sample (w_sample)
  );

  // Samples only matter while bits are being collected; the wait states ignore the line.
  assign w_sampling = w_sample &&
                      (r_state inside {SYNC_RCV, CHK_SYNC, RCV_BYTE, STORE});
  assign w_stuffed  = (r_onesCnt == ONES_W'(STUFF_LIMIT));
  assign w_stuffErr = w_sampling && w_stuffed && d_orig;
  assign w_startPkt = ((r_state == IDLE) || (r_state == EIDLE)) && d_edge;
  assign w_eopFall  = r_eopD && !eop;

  assign shift_enable  = w_sampling && !w_stuffed;
  assign byte_received = r_byteRcvd;
  assign rcving        = w_rcving;
  assign w_enable      = w_wEnable;
  assign r_error       = r_err;

  // Unstuffing and accepted-bit counters; a stuffed sample only clears the ones run.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_bitCnt   <= '0;
      r_onesCnt  <= '0;
      r_byteRcvd <= 1'b0;
      r_eopD     <= 1'b0;
    end else begin
      r_eopD     <= eop;
      r_byteRcvd <= shift_enable && (r_bitCnt == 3'd7);
      if (w_startPkt) begin
        r_bitCnt  <= '0;
        r_onesCnt <= '0;
      end else if (w_sampling) begin
        if (w_stuffed) begin
          r_onesCnt <= '0;
        end else begin
          r_bitCnt  <= r_bitCnt + 3'd1;
          r_onesCnt <= d_orig ? (r_onesCnt + 1'b1) : '0;
        end
      end
    end
  end

  // State register plus the sticky error flag, which survives until a new packet starts.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if ((w_nextState == ERR_WAIT) && (r_state != ERR_WAIT)) begin
        r_err <= 1'b1;
      end else if (w_startPkt) begin
        r_err <= 1'b0;
      end
    end
  end

  // Next-state and state-decoded outputs; eop outranks a completed byte in RCV_BYTE.
  always_comb begin
    w_nextState = r_state;
    w_rcving    = isRcving(r_state);
    w_wEnable   = 1'b0;
    case (r_state)
      IDLE, EIDLE: begin
        if (d_edge) w_nextState = SYNC_RCV;
      end
      SYNC_RCV: begin
        if (w_stuffErr)      w_nextState = ERR_WAIT;
        else if (r_byteRcvd) w_nextState = CHK_SYNC;
      end
      CHK_SYNC: begin
        w_nextState = (rcv_data == SYNC_BYTE) ? RCV_BYTE : ERR_WAIT;
      end
      RCV_BYTE: begin
        if (eop)             w_nextState = (r_bitCnt == 3'd0) ? EOP_WAIT : ERR_WAIT;
        else if (w_stuffErr) w_nextState = ERR_WAIT;
        else if (r_byteRcvd) w_nextState = STORE;
      end
      STORE: begin
        w_wEnable   = 1'b1;
        w_nextState = RCV_BYTE;
      end
      EOP_WAIT: begin
        if (w_eopFall) w_nextState = IDLE;
      end
      ERR_WAIT: begin
        if (w_eopFall) w_nextState = EIDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Self-checking bench for usb_rx_ctrl: drives decoded bit cells, models the
// external shift register and scoreboards every FIFO write.
module tb_usb_rx_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_edge;
  logic       eop;
  logic       d_orig;
  logic [7:0] rcvData;
  logic       shift_enable;
  logic       byte_received;
  logic       rcving;
  logic       w_enable;
  logic       r_error;

  int total   = 0;
  int bad     = 0;
  int seCount = 0;
  int brCount = 0;
  int weCount = 0;
  logic [7:0] expQ[$];

  always #5 clk = ~clk;

  usb_rx_ctrl dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .d_edge        (d_edge),
    .eop           (eop),
    .d_orig        (d_orig),
    .rcv_data      (rcvData),
    .shift_enable  (shift_enable),
    .byte_received (byte_received),
    .rcving        (rcving),
    .w_enable      (w_enable),
    .r_error       (r_error)
  );

  // Stand-in for the external LSB-first shift register fed by shift_enable.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) rcvData <= '0;
    else if (shift_enable) rcvData <= {d_orig, rcvData[7:1]};
  end

  // Scoreboard: every FIFO write must match the oldest expected byte.
  always @(negedge clk) begin
    logic [7:0] expVal;
    if (n_rst) begin
      if (shift_enable) seCount++;
      if (byte_received) brCount++;
      if (w_enable) begin
        weCount++;
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL store_unexpected: got rcv_data=%h want no write", rcvData);
        end else begin
          expVal = expQ.pop_front();
          if (rcvData !== expVal) begin
            bad++;
            $display("[TB] FAIL store_data: got %h want %h", rcvData, expVal);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyReset();
    n_rst = 1'b0; d_edge = 1'b0; eop = 1'b0; d_orig = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    expQ.delete();
  endtask

  task automatic sendBit(input logic b, input int eopFrom);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      d_edge = (c == 0);
      d_orig = b;
      eop    = (c >= eopFrom);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input bit push);
    if (push) expQ.push_back(b);
    for (int i = 0; i < 8; i++) sendBit(b[i], 8);
  endtask

  task automatic idleCycles(input int n, input logic eopVal);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      d_edge = 1'b0;
      eop    = eopVal;
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; d_edge = 1'b0; eop = 1'b0; d_orig = 1'b0;
    #3;
    total++; if (shift_enable !== 1'b0) begin bad++; $display("[TB] FAIL reset_shift: got %b want 0", shift_enable); end
    total++; if (byte_received !== 1'b0) begin bad++; $display("[TB] FAIL reset_byte: got %b want 0", byte_received); end
    total++; if (rcving !== 1'b0) begin bad++; $display("[TB] FAIL reset_rcving: got %b want 0", rcving); end
    total++; if (w_enable !== 1'b0) begin bad++; $display("[TB] FAIL reset_wen: got %b want 0", w_enable); end
    total++; if (r_error !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", r_error); end
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    idleCycles(4, 1'b0);
    @(negedge clk);
    total++; if (rcving !== 1'b0) begin bad++; $display("[TB] FAIL idle_rcving: got %b want 0", rcving); end
  endtask

  task automatic test_timer();
    logic [31:0] mask;
    logic [31:0] expMask;
    for (int r = 0; r < 2; r++) begin
      mask    = '0;
      expMask = (r == 1) ? 32'h0002_0808 : 32'h0008_0808;
      for (int c = 0; c <= 20; c++) begin
        @(posedge clk); #1;
        d_edge = (c == 0) || ((r == 1) && (c == 14));
        d_orig = 1'b0;
        eop    = 1'b0;
        @(negedge clk);
        if (shift_enable) mask[c] = 1'b1;
      end
      total++; if (mask !== expMask) begin bad++; $display("[TB] FAIL timer_samples_%0d: got %h want %h", r, mask, expMask); end
      total++; if (rcving !== 1'b1) begin bad++; $display("[TB] FAIL timer_rcving_%0d: got %b want 1", r, rcving); end
      #1 n_rst = 1'b0;
      #1;
      total++;
      if ({shift_enable, byte_received, rcving, w_enable, r_error} !== 5'b0) begin
        bad++;
        $display("[TB] FAIL reset_midbyte_%0d: got %b want 00000", r,
                 {shift_enable, byte_received, rcving, w_enable, r_error});
      end
      @(posedge clk); #1 n_rst = 1'b1;
    end
  endtask

  task automatic test_packet();
    int w0;
    w0 = weCount;
    sendByte(8'h80, 1'b0);
    sendByte(8'hA5, 1'b1);
    sendByte(8'h3C, 1'b1);
    idleCycles(6, 1'b1);
    @(negedge clk);
    total++; if (rcving !== 1'b1) begin bad++; $display("[TB] FAIL pkt_eopwait_rcving: got %b want 1", rcving); end
    idleCycles(3, 1'b0);
    @(negedge clk);
    total++; if (rcving !== 1'b0) begin bad++; $display("[TB] FAIL pkt_idle_rcving: got %b want 0", rcving); end
    total++; if (r_error !== 1'b0) begin bad++; $display("[TB] FAIL pkt_err: got %b want 0", r_error); end
    total++; if (weCount - w0 !== 2) begin bad++; $display("[TB] FAIL pkt_writes: got %0d want 2", weCount - w0); end
    total++; if (expQ.size() !== 0) begin bad++; $display("[TB] FAIL pkt_pending: got %0d want 0", expQ.size()); end
  endtask

  task automatic test_stuff();
    logic [7:0] bits;
    int s0;
    int b0;
    sendByte(8'h80, 1'b0);
    sendByte(8'h00, 1'b1);
    s0   = seCount;
    b0   = brCount;
    bits = 8'b1011_1111;
    for (int i = 0; i < 8; i++) sendBit(bits[i], 8);
    total++; if (seCount - s0 !== 7) begin bad++; $display("[TB] FAIL stuff_shifts: got %0d want 7", seCount - s0); end
    total++; if (brCount - b0 !== 0) begin bad++; $display("[TB] FAIL stuff_early_byte: got %0d want 0", brCount - b0); end
    expQ.push_back(8'h7F);
    sendBit(1'b0, 8);
    total++; if (brCount - b0 !== 1) begin bad++; $display("[TB] FAIL stuff_byte: got %0d want 1", brCount - b0); end
    idleCycles(6, 1'b1);
    idleCycles(3, 1'b0);
    @(negedge clk);
    total++; if (r_error !== 1'b0) begin bad++; $display("[TB] FAIL stuff_err: got %b want 0", r_error); end
    total++; if (expQ.size() !== 0) begin bad++; $display("[TB] FAIL stuff_pending: got %0d want 0", expQ.size()); end
  endtask

  task automatic test_stuff_error();
    sendByte(8'h80, 1'b0);
    sendByte(8'h00, 1'b1);
    for (int i = 0; i < 6; i++) sendBit(1'b1, 8);
    sendBit(1'b1, 4);
    @(negedge clk);
    total++; if (r_error !== 1'b1) begin bad++; $display("[TB] FAIL stufferr_flag: got %b want 1", r_error); end
    idleCycles(4, 1'b1);
    @(negedge clk);
    total++; if (rcving !== 1'b1) begin bad++; $display("[TB] FAIL stufferr_wait_rcving: got %b want 1", rcving); end
    idleCycles(3, 1'b0);
    @(negedge clk);
    total++; if (rcving !== 1'b0) begin bad++; $display("[TB] FAIL stufferr_eidle_rcving: got %b want 0", rcving); end
    total++; if (r_error !== 1'b1) begin bad++; $display("[TB] FAIL stufferr_eidle_flag: got %b want 1", r_error); end
    sendBit(1'b0, 8);
    @(negedge clk);
    total++; if (r_error !== 1'b0) begin bad++; $display("[TB] FAIL stufferr_clear: got %b want 0", r_error); end
    total++; if (rcving !== 1'b1) begin bad++; $display("[TB] FAIL stufferr_restart: got %b want 1", rcving); end
    total++; if (expQ.size() !== 0) begin bad++; $display("[TB] FAIL stufferr_pending: got %0d want 0", expQ.size()); end
    applyReset();
  endtask

  task automatic test_bad_sync();
    int w0;
    w0 = weCount;
    sendByte(8'h81, 1'b0);
    sendByte(8'h3C, 1'b0);
    idleCycles(4, 1'b1);
    @(negedge clk);
    total++; if (r_error !== 1'b1) begin bad++; $display("[TB] FAIL badsync_flag: got %b want 1", r_error); end
    idleCycles(3, 1'b0);
    @(negedge clk);
    total++; if (rcving !== 1'b0) begin bad++; $display("[TB] FAIL badsync_eidle: got %b want 0", rcving); end
    total++; if (weCount - w0 !== 0) begin bad++; $display("[TB] FAIL badsync_writes: got %0d want 0", weCount - w0); end
    #1 n_rst = 1'b0;
    #1;
    total++; if (r_error !== 1'b0) begin bad++; $display("[TB] FAIL badsync_reset_flag: got %b want 0", r_error); end
    @(posedge clk); #1 n_rst = 1'b1;
  endtask

  task automatic test_eop_mid();
    logic [4:0] bits;
    int w0;
    w0   = weCount;
    bits = 5'b10101;
    sendByte(8'h80, 1'b0);
    for (int i = 0; i < 5; i++) sendBit(bits[i], 8);
    idleCycles(4, 1'b1);
    @(negedge clk);
    total++; if (r_error !== 1'b1) begin bad++; $display("[TB] FAIL eopmid_flag: got %b want 1", r_error); end
    idleCycles(3, 1'b0);
    @(negedge clk);
    total++; if (rcving !== 1'b0) begin bad++; $display("[TB] FAIL eopmid_eidle: got %b want 0", rcving); end
    total++; if (weCount - w0 !== 0) begin bad++; $display("[TB] FAIL eopmid_writes: got %0d want 0", weCount - w0); end
    applyReset();
  endtask

  task automatic test_eop_priority();
    logic [7:0] bits;
    int w0;
    w0   = weCount;
    bits = 8'h11;
    sendByte(8'h80, 1'b0);
    for (int i = 0; i < 7; i++) sendBit(bits[i], 8);
    sendBit(bits[7], 4);
    idleCycles(4, 1'b1);
    idleCycles(3, 1'b0);
    @(negedge clk);
    total++; if (weCount - w0 !== 0) begin bad++; $display("[TB] FAIL eopprio_writes: got %0d want 0", weCount - w0); end
    total++; if (r_error !== 1'b0) begin bad++; $display("[TB] FAIL eopprio_flag: got %b want 0", r_error); end
    total++; if (rcving !== 1'b0) begin bad++; $display("[TB] FAIL eopprio_idle: got %b want 0", rcving); end
  endtask

  initial begin
    test_reset();
    test_timer();
    test_packet();
    test_stuff();
    test_stuff_error();
    test_bad_sync();
    test_eop_mid();
    test_eop_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_rx_ctrl.md
USB_RX_CTRL -- requirements
Module: usb_rx_ctrl

Interface
REQ-001 SHALL provide port: clk  input  1  system clock, 8x the USB bit rate.
REQ-002 SHALL provide port: n_rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide port: d_edge  input  1  one-cycle pulse on any synchronized D+ transition.
REQ-004 SHALL provide port: eop  input  1  synchronized end-of-packet (D+ and D- both low).
REQ-005 SHALL provide port: d_orig  input  1  NRZI-decoded bit from the decoder.
REQ-006 SHALL provide port: rcv_data  input  8  LSB-first shift register contents.
REQ-007 SHALL provide port: shift_enable  output  1  one-cycle strobe shifting d_orig into the shift register, stuffed bits excluded.
REQ-008 SHALL provide port: byte_received  output  1  one-cycle pulse after the 8th accepted bit.
REQ-009 SHALL provide port: rcving  output  1  packet reception in progress.
REQ-010 SHALL provide port: w_enable  output  1  one-cycle FIFO write strobe for rcv_data.
REQ-011 SHALL provide port: r_error  output  1  sticky receive error flag.
REQ-012 SHALL provide parameters: SYNC_BYTE 8'h80, expected decoded sync byte; STUFF_LIMIT 6, consecutive ones before a stuffed bit.

Function
REQ-013 SHALL keep a 3-bit phase counter: set to 0 on a d_edge cycle, otherwise increment mod 8 while rcving, and hold at 0 while not rcving.
REQ-014 SHALL raise a raw sample strobe when the phase counter equals 3 and d_edge is low, giving the first sample 3 cycles after the edge and then every 8 cycles.
REQ-015 SHALL count consecutive sampled ones, clearing the count on a sampled zero.
REQ-016 SHALL treat the sample after STUFF_LIMIT ones as stuffed: suppress shift_enable for it, exclude it from the bit count, and clear the ones count.
REQ-017 SHALL flag a stuffed sample equal to 1 as a stuff error, with the same effect as REQ-024.
REQ-018 SHALL drive shift_enable as the raw sample strobe with stuffed samples removed, with zero added latency.
REQ-019 SHALL keep a 3-bit accepted-bit counter that wraps 7->0 and pulses byte_received in the cycle after the 8th shift_enable.
REQ-020 SHALL implement FSM states IDLE, SYNC_RCV, CHK_SYNC, RCV_BYTE, STORE, EOP_WAIT, ERR_WAIT, EIDLE.
REQ-021 SHALL transition IDLE -> SYNC_RCV on d_edge and clear the bit and stuff counters.
REQ-022 SHALL transition SYNC_RCV -> CHK_SYNC on byte_received.
REQ-023 SHALL transition CHK_SYNC -> RCV_BYTE when rcv_data equals SYNC_BYTE, otherwise -> ERR_WAIT.
REQ-024 SHALL transition RCV_BYTE -> STORE on byte_received; -> EOP_WAIT on eop with bit count 0; -> ERR_WAIT on eop with bit count nonzero or on a stuff error.
REQ-025 SHALL assert w_enable for exactly the single STORE cycle, then transition unconditionally to RCV_BYTE.
REQ-026 SHALL transition EOP_WAIT -> IDLE when eop deasserts.
REQ-027 SHALL transition ERR_WAIT -> EIDLE when eop deasserts.
REQ-028 SHALL transition EIDLE -> SYNC_RCV on d_edge.
REQ-029 SHALL set r_error on entry to ERR_WAIT, hold it through EIDLE, and clear it only on the EIDLE -> SYNC_RCV or IDLE -> SYNC_RCV transition.
REQ-030 SHALL drive rcving high in SYNC_RCV, CHK_SYNC, RCV_BYTE, STORE, EOP_WAIT and ERR_WAIT, and low in IDLE and EIDLE.
REQ-031 SHALL give eop priority over byte_received when both occur in the same RCV_BYTE cycle, taking the eop rule of REQ-024.
REQ-032 SHALL ignore d_edge in every state except IDLE and EIDLE, apart from its timer resync effect.

Reset
REQ-033 SHALL on n_rst low immediately set the state to IDLE, all counters to 0, and shift_enable, byte_received, rcving, w_enable and r_error to 0.
REQ-034 SHALL abandon any in-progress packet on reset mid-reception without issuing w_enable.

Structure
REQ-035 SHALL define the state enum, SYNC_BYTE, STUFF_LIMIT, BIT_PERIOD=8 and SAMPLE_PHASE=3 in shared package usb_rx_pkg.
REQ-036 SHALL place the phase counter and raw sample strobe in sub-module rx_timer; the FSM, unstuffing and bit counting SHALL stay in usb_rx_ctrl.

Verification
REQ-037 SHALL cover: d_edge at cycle 0, then no edges -> raw samples at cycles 3, 11, 19; d_edge at cycle 14 -> next sample at cycle 17.
REQ-038 SHALL cover: sync byte 8'h80, one data byte 8'hA5, then eop on a byte boundary -> w_enable once with rcv_data 8'hA5, r_error 0, IDLE after eop drops.
REQ-039 SHALL cover: decoded bits 1,1,1,1,1,1,0,1 -> seven shift_enable pulses (stuffed 0 skipped), bit count advances by 7.
REQ-040 SHALL cover: six ones followed by a stuffed 1 -> r_error 1, ERR_WAIT, EIDLE after eop, r_error cleared on the next d_edge.
REQ-041 SHALL cover: sync byte 8'h81 -> r_error 1, no w_enable for the whole packet.
REQ-042 SHALL cover: eop after 5 data bits -> r_error 1; n_rst asserted mid-byte -> all outputs 0 within the same cycle.
